// File: rtl/train_scheduler.sv
// train_scheduler: runs the forward layers 0..LAYER_MAX-1 and then backprop layers LAYER_MAX-1..1 for every sample of every epoch.
// Define SCHED_WATCHDOG_EN to add a wait-state timeout that drops to IDLE and bumps error_count.
module train_scheduler #(
  parameter int LAYER_ADDR_WIDTH = 2,
  parameter int LAYER_MAX        = 3,
  parameter int SAMPLE_ADDR_SIZE = 10,
  parameter int MAX_SAMPLES      = 1000,
  parameter int EPOCH_WIDTH      = 8,
  parameter int ERR_CNT_WIDTH    = 16,
  parameter int WATCHDOG_CYCLES  = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        hold,
  input  logic [EPOCH_WIDTH-1:0]      num_epochs,
  input  logic                        fp_done,
  input  logic                        bp_done,
  input  logic                        bp_error,
  output logic                        fp_start,
  output logic                        bp_start,
  output logic [LAYER_ADDR_WIDTH-1:0] current_layer,
  output logic [SAMPLE_ADDR_SIZE-1:0] current_sample,
  output logic [EPOCH_WIDTH-1:0]      current_epoch,
  output logic                        busy,
  output logic                        paused,
  output logic                        done,
  output logic [ERR_CNT_WIDTH-1:0]    error_count
);

  typedef enum logic [1:0] {S_IDLE, S_FP_WAIT, S_BP_WAIT, S_PAUSE} state_t;

  localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_LAST  = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
  localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_ONE   = LAYER_ADDR_WIDTH'(1);
  localparam logic [SAMPLE_ADDR_SIZE-1:0] SAMPLE_LAST = SAMPLE_ADDR_SIZE'(MAX_SAMPLES - 1);

  state_t                      r_state, w_state;
  logic [LAYER_ADDR_WIDTH-1:0] r_layer, w_layer;
  logic [SAMPLE_ADDR_SIZE-1:0] r_sample, w_sample;
  logic [EPOCH_WIDTH-1:0]      r_epoch, w_epoch;
  logic [EPOCH_WIDTH-1:0]      r_epoch_lim, w_epoch_lim;
  logic [ERR_CNT_WIDTH-1:0]    r_err, w_err;
  logic                        r_fp_start, w_fp_start;
  logic                        r_bp_start, w_bp_start;
  logic                        r_done, w_done;
  logic                        r_busy, r_paused;
  logic                        w_last_sample;
  logic                        w_wd_expire;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_CNT_WIDTH'(1);
  endfunction

`ifdef SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] r_wd;

  assign w_wd_expire = (r_wd == WD_W'(WATCHDOG_CYCLES - 1));

  // Restarts on every launch so each layer gets its own full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wd <= '0;
    else if (w_fp_start || w_bp_start || (w_state != S_FP_WAIT && w_state != S_BP_WAIT))
      r_wd <= '0;
    else
      r_wd <= r_wd + WD_W'(1);
  end
`else
  // Always false; WATCHDOG_CYCLES only matters when the watchdog is built in.
  assign w_wd_expire = (WATCHDOG_CYCLES < 0);
`endif

  assign w_last_sample = (r_sample == SAMPLE_LAST) &&
                         (r_epoch == r_epoch_lim - EPOCH_WIDTH'(1));

  always_comb begin
    w_state     = r_state;
    w_layer     = r_layer;
    w_sample    = r_sample;
    w_epoch     = r_epoch;
    w_epoch_lim = r_epoch_lim;
    w_err       = r_err;
    w_fp_start  = 1'b0;
    w_bp_start  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_epochs == '0) begin
            w_done = 1'b1;
          end else begin
            w_state     = S_FP_WAIT;
            w_fp_start  = 1'b1;
            w_layer     = '0;
            w_sample    = '0;
            w_epoch     = '0;
            w_err       = '0;
            w_epoch_lim = num_epochs;
          end
        end
      end
      S_FP_WAIT: begin
        if (fp_done) begin
          if (r_layer < LAYER_LAST) begin
            w_layer    = r_layer + LAYER_ONE;
            w_fp_start = 1'b1;
          end else begin
            w_state    = S_BP_WAIT;
            w_bp_start = 1'b1;
          end
        end else if (w_wd_expire) begin
          w_state  = S_IDLE;
          w_layer  = '0;
          w_sample = '0;
          w_err    = sat_inc(r_err);
        end
      end
      S_BP_WAIT: begin
        if (bp_done) begin
          if (bp_error) w_err = sat_inc(r_err);
          if (r_layer > LAYER_ONE) begin
            w_layer    = r_layer - LAYER_ONE;
            w_bp_start = 1'b1;
          end else if (w_last_sample) begin
            // Final sample/epoch stay visible after the run ends.
            w_state = S_IDLE;
            w_done  = 1'b1;
          end else begin
            if (r_sample == SAMPLE_LAST) begin
              w_sample = '0;
              w_epoch  = r_epoch + EPOCH_WIDTH'(1);
            end else begin
              w_sample = r_sample + SAMPLE_ADDR_SIZE'(1);
            end
            w_layer = '0;
            if (hold) begin
              w_state = S_PAUSE;
            end else begin
              w_state    = S_FP_WAIT;
              w_fp_start = 1'b1;
            end
          end
        end else if (w_wd_expire) begin
          w_state  = S_IDLE;
          w_layer  = '0;
          w_sample = '0;
          w_err    = sat_inc(r_err);
        end
      end
      S_PAUSE: begin
        if (!hold) begin
          w_state    = S_FP_WAIT;
          w_fp_start = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
    // Abort wins over any done input arriving in the same cycle.
    if (abort && r_state != S_IDLE) begin
      w_state    = S_IDLE;
      w_layer    = '0;
      w_sample   = '0;
      w_epoch    = r_epoch;
      w_err      = r_err;
      w_fp_start = 1'b0;
      w_bp_start = 1'b0;
      w_done     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_layer     <= '0;
      r_sample    <= '0;
      r_epoch     <= '0;
      r_epoch_lim <= '0;
      r_err       <= '0;
      r_fp_start  <= 1'b0;
      r_bp_start  <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_paused    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_layer     <= w_layer;
      r_sample    <= w_sample;
      r_epoch     <= w_epoch;
      r_epoch_lim <= w_epoch_lim;
      r_err       <= w_err;
      r_fp_start  <= w_fp_start;
      r_bp_start  <= w_bp_start;
      r_done      <= w_done;
      r_busy      <= (w_state != S_IDLE);
      r_paused    <= (w_state == S_PAUSE);
    end
  end

  assign fp_start       = r_fp_start;
  assign bp_start       = r_bp_start;
  assign current_layer  = r_layer;
  assign current_sample = r_sample;
  assign current_epoch  = r_epoch;
  assign busy           = r_busy;
  assign paused         = r_paused;
  assign done           = r_done;
  assign error_count    = r_err;

endmodule

// File: tb/tb_train_scheduler.sv
// tb_train_scheduler: randomized launch/done traffic checked against an expected launch list built per run.
module tb_train_scheduler;
  localparam int LW = 2, LM = 3, SW = 3, MS = 4, EW = 8, CW = 2;
  localparam int ERR_MAX = (1 << CW) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, hold = 1'b0;
  logic fp_done = 1'b0, bp_done = 1'b0, bp_error = 1'b0;
  logic [EW-1:0] num_epochs = '0;
  logic fp_start, bp_start, busy, paused, done;
  logic [LW-1:0] current_layer;
  logic [SW-1:0] current_sample;
  logic [EW-1:0] current_epoch;
  logic [CW-1:0] error_count;

  int total = 0, bad = 0;

  typedef struct { bit bp; int layer; int sample; int epoch; } launch_t;
  launch_t exp_q[$];

  always #5 clk = ~clk;

  train_scheduler #(
    .LAYER_ADDR_WIDTH(LW), .LAYER_MAX(LM), .SAMPLE_ADDR_SIZE(SW), .MAX_SAMPLES(MS),
    .EPOCH_WIDTH(EW), .ERR_CNT_WIDTH(CW), .WATCHDOG_CYCLES(4096)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .num_epochs(num_epochs), .fp_done(fp_done), .bp_done(bp_done), .bp_error(bp_error),
    .fp_start(fp_start), .bp_start(bp_start), .current_layer(current_layer),
    .current_sample(current_sample), .current_epoch(current_epoch), .busy(busy),
    .paused(paused), .done(done), .error_count(error_count)
  );

  task automatic check_eq(input string tag, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_fp_start"}, fp_start, 0);
    check_eq({tag, "_bp_start"}, bp_start, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_paused"}, paused, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  // One full run: the expected launch order is listed up front, the bench answers
  // each launch after a random delay and predicts pause/done/error from the rules.
  task automatic run(input int ne, input int dmin, input int dmax, input int hold_pct,
                     input int err_pct, input int stray_pct);
    launch_t it;
    int pend, pend_layer, fpc, bpc, cyc, m_err;
    bit pend_bp, m_start, m_done, m_paused, m_busy, fin, was_paused, wait_bp;
    exp_q.delete();
    for (int e = 0; e < ne; e++)
      for (int s = 0; s < MS; s++) begin
        for (int l = 0; l < LM; l++) exp_q.push_back('{1'b0, l, s, e});
        for (int l = LM - 1; l >= 1; l--) exp_q.push_back('{1'b1, l, s, e});
      end
    fpc = 0; bpc = 0; cyc = 0; fin = 0; pend = -1; pend_bp = 0; pend_layer = 0;
    m_start = 1; m_done = 0; m_paused = 0; m_busy = 1; m_err = 0;
    start = 1'b1; num_epochs = EW'(ne);
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 5000) begin
      cyc++;
      check_eq("busy", busy, m_busy);
      check_eq("paused", paused, m_paused);
      check_eq("done", done, m_done);
      check_eq("start_pulse", fp_start | bp_start, m_start);
      check_eq("fp_bp_overlap", fp_start & bp_start, 0);
      check_eq("error_count", error_count, m_err);
      if (fp_start | bp_start) begin
        check_eq("launch_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          it = exp_q.pop_front();
          check_eq("launch_is_bp", bp_start, it.bp);
          check_eq("launch_layer", current_layer, it.layer);
          check_eq("launch_sample", current_sample, it.sample);
          check_eq("launch_epoch", current_epoch, it.epoch);
          fpc += fp_start; bpc += bp_start;
          pend = $urandom_range(dmax, dmin) - 1;
          pend_bp = it.bp; pend_layer = it.layer;
        end
      end
      if (done) fin = 1;
      fp_done = 1'b0; bp_done = 1'b0; bp_error = 1'b0;
      hold = ($urandom_range(99) < hold_pct);
      m_start = 0; m_done = 0;
      if (!fin) begin
        was_paused = m_paused; wait_bp = pend_bp;
        if (m_paused) begin
          if (!hold) begin m_paused = 0; m_start = 1; end
        end else if (pend == 0) begin
          if (!pend_bp) begin
            fp_done = 1'b1; m_start = 1;
          end else begin
            bp_done = 1'b1;
            bp_error = ($urandom_range(99) < err_pct);
            if (bp_error) m_err = (m_err >= ERR_MAX) ? ERR_MAX : m_err + 1;
            if (pend_layer > 1) m_start = 1;
            else if (exp_q.size() == 0) begin m_done = 1; m_busy = 0; end
            else if (hold) m_paused = 1;
            else m_start = 1;
          end
          pend = -1;
        end else if (pend > 0) pend--;
        if ($urandom_range(99) < stray_pct) begin
          if (was_paused) begin fp_done = 1'b1; bp_done = 1'b1; bp_error = 1'($urandom_range(1)); end
          else if (wait_bp) fp_done = 1'b1;
          else begin bp_done = 1'b1; bp_error = 1'($urandom_range(1)); end
        end
      end
      @(negedge clk);
    end
    fp_done = 1'b0; bp_done = 1'b0; bp_error = 1'b0; hold = 1'b0;
    check_eq("run_finished", fin, 1);
    check_eq("fp_start_count", fpc, ne * MS * LM);
    check_eq("bp_start_count", bpc, ne * MS * (LM - 1));
    check_eq("launches_left", exp_q.size(), 0);
    check_eq("final_sample", current_sample, MS - 1);
    check_eq("final_epoch", current_epoch, ne - 1);
    check_eq("final_error_count", error_count, m_err);
    check_idle_outputs("after_done");
  endtask

  initial begin
    int cyc;
    bit hit;
    logic [CW-1:0] err_before;
    logic [EW-1:0] ep_before;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset_layer", current_layer, 0);
    check_eq("reset_sample", current_sample, 0);
    check_eq("reset_epoch", current_epoch, 0);
    check_eq("reset_err", error_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Zero epochs: immediate done, nothing launched.
    start = 1'b1; num_epochs = '0;
    @(negedge clk);
    start = 1'b0;
    check_eq("zero_ep_done", done, 1);
    check_eq("zero_ep_busy", busy, 0);
    check_eq("zero_ep_fp_start", fp_start, 0);
    @(negedge clk);
    check_idle_outputs("zero_ep_after");

    run(2, 2, 2, 0, 0, 0);

    // Stray done inputs while idle change nothing.
    fp_done = 1'b1; bp_done = 1'b1; bp_error = 1'b1;
    @(negedge clk);
    fp_done = 1'b0; bp_done = 1'b0; bp_error = 1'b0;
    check_idle_outputs("stray_idle");
    check_eq("stray_idle_err", error_count, 0);
    check_eq("stray_idle_sample", current_sample, MS - 1);

    run(1, 1, 4, 30, 100, 30);
    for (int r = 0; r < 3; r++)
      run($urandom_range(3, 1), 1, 4, 25, 40, 25);

    // Abort together with a forward-layer done.
    start = 1'b1; num_epochs = 8'd2;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; hit = 0; err_before = '0; ep_before = '0;
    while (!hit && cyc < 500) begin
      cyc++;
      fp_done = 1'b0; bp_done = 1'b0; bp_error = 1'b0;
      if (fp_start && current_layer == 1 && current_sample == 2) begin
        hit = 1; fp_done = 1'b1; abort = 1'b1;
        err_before = error_count; ep_before = current_epoch;
      end else begin
        fp_done = fp_start; bp_done = bp_start; bp_error = bp_start;
        @(negedge clk);
      end
    end
    check_eq("abort_point_reached", hit, 1);
    @(negedge clk);
    fp_done = 1'b0; abort = 1'b0;
    check_idle_outputs("abort");
    check_eq("abort_layer", current_layer, 0);
    check_eq("abort_sample", current_sample, 0);
    check_eq("abort_epoch_hold", current_epoch, ep_before);
    check_eq("abort_err_hold", error_count, err_before);
    check_eq("abort_err_value", error_count, ERR_MAX);
    @(negedge clk);
    check_idle_outputs("abort_later");

    // Asynchronous reset in the middle of a run.
    start = 1'b1; num_epochs = 8'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      fp_done = fp_start; bp_done = bp_start; bp_error = bp_start;
      @(negedge clk);
    end
    fp_done = 1'b0; bp_done = 1'b0; bp_error = 1'b0;
    check_eq("pre_rst_busy", busy, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check_eq("async_rst_layer", current_layer, 0);
    check_eq("async_rst_sample", current_sample, 0);
    check_eq("async_rst_epoch", current_epoch, 0);
    check_eq("async_rst_err", error_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/train_scheduler.md
Name: train_scheduler

Overview:
Sequences one full training run for the shared forward/backpropagator datapath over samples and epochs.
- Forward pass runs layers 0..LAYER_MAX-1; backprop runs layers LAYER_MAX-1 down to 1.
- Drives current_layer and current_sample for the input BRAM, the activation stack and the backpropagator.
- Uses clean start/done handshakes and adds epoch counting, pause at sample boundaries, abort and error counting.

Parameters:
LAYER_ADDR_WIDTH, 2, width of current_layer
LAYER_MAX, 3, number of layers; must be >= 2
SAMPLE_ADDR_SIZE, 10, width of current_sample
MAX_SAMPLES, 1000, samples per epoch; must be <= 2^SAMPLE_ADDR_SIZE
EPOCH_WIDTH, 8, width of epoch counters
ERR_CNT_WIDTH, 16, width of error_count
WATCHDOG_CYCLES, 4096, wait-state timeout (watchdog option only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin run; sampled only in IDLE
abort  in  1  stop run, return to IDLE
hold  in  1  pause at next sample boundary
num_epochs  in  EPOCH_WIDTH  epochs to run; latched on accepted start
fp_done  in  1  forward layer finished (1-cycle pulse)
bp_done  in  1  backprop layer finished (1-cycle pulse)
bp_error  in  1  qualifies bp_done; counted
fp_start  out  1  1-cycle pulse, launch forward layer
bp_start  out  1  1-cycle pulse, launch backprop layer
current_layer  out  LAYER_ADDR_WIDTH  active layer
current_sample  out  SAMPLE_ADDR_SIZE  active sample index
current_epoch  out  EPOCH_WIDTH  active epoch
busy  out  1  high in any state except IDLE
paused  out  1  high in PAUSE
done  out  1  1-cycle pulse, run complete
error_count  out  ERR_CNT_WIDTH  saturating count of bp_done&&bp_error

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0; latched epoch limit 0.
- All outputs are registered.
- States: IDLE, FP_WAIT, BP_WAIT, PAUSE.
- IDLE, start=1 at edge N:
  - num_epochs=0: done=1 at N+1; stay IDLE; no fp_start.
  - Otherwise at N+1: fp_start=1, current_layer=0, sample=0, epoch=0, error_count=0, state FP_WAIT.
- FP_WAIT, fp_done=1 at edge M:
  - current_layer < LAYER_MAX-1: at M+1 layer+1, fp_start=1.
  - current_layer = LAYER_MAX-1: at M+1 bp_start=1, layer unchanged, state BP_WAIT.
- BP_WAIT, bp_done=1 at edge M:
  - current_layer > 1: at M+1 layer-1, bp_start=1.
  - current_layer = 1: sample boundary (next bullet).
- Sample boundary:
  - If sample = MAX_SAMPLES-1: sample wraps to 0 and epoch+1.
  - Otherwise: sample+1.
  - If the completed sample was the last sample of epoch num_epochs-1: done=1, state IDLE. current_sample/current_epoch then hold their final values (MAX_SAMPLES-1 and num_epochs-1).
  - Else if hold=1: state PAUSE, layer=0, no fp_start.
  - Else: layer=0, fp_start=1 at M+1, state FP_WAIT.
- PAUSE, hold=0: fp_start=1 next cycle, state FP_WAIT.
- Done-input filtering:
  - fp_done is ignored outside FP_WAIT; bp_done is ignored outside BP_WAIT.
  - Simultaneous fp_done and bp_done in FP_WAIT: only fp_done acts.
- abort=1 in any non-IDLE state:
  - State IDLE next cycle; no start pulse and no done.
  - Layer and sample cleared to 0; epoch and error_count hold.
  - abort has priority over every done input.
- start outside IDLE is ignored. start held high continuously restarts a new run the cycle after done.
- error_count increments on bp_done&&bp_error in BP_WAIT and saturates at all-ones. It does not alter sequencing.
- Per sample: exactly LAYER_MAX fp_start and LAYER_MAX-1 bp_start pulses. fp_start and bp_start are never high together.

Optional Feature:
SCHED_WATCHDOG_EN:
- Defined:
  - A counter runs while in FP_WAIT or BP_WAIT and clears on every start pulse.
  - On reaching WATCHDOG_CYCLES with no done: state IDLE, error_count+1 (saturating), done not asserted.
- Undefined: no counter; waits indefinitely.

Test Plan:
- LAYER_MAX=3, MAX_SAMPLES=4, num_epochs=2, done inputs 2 cycles after each start -> 24 fp_start and 16 bp_start pulses; layer sequence per sample 0,1,2 then 2,1; one done pulse; final sample=3, epoch=1.
- num_epochs=0, start=1 -> done=1 next cycle; fp_start never asserted; busy stays 0.
- hold=1 during sample 1's last bp_done -> PAUSE, paused=1, no fp_start for 10 cycles; hold=0 -> fp_start one cycle later with sample=2, layer=0.
- abort=1 in the same cycle as fp_done (layer 1) -> IDLE next cycle, no fp_start, layer=0, sample=0, busy=0.
- bp_error=1 on 3 bp_done pulses, ERR_CNT_WIDTH=2 -> error_count saturates at 3; sequencing unchanged.
- Stray fp_done in BP_WAIT and stray bp_done in IDLE -> no state or counter change; rst_n low mid-run -> all outputs 0 immediately (asynchronous).
